// File: rtl/dijkstra_path_tracer.sv
// Purpose : walks the parent[] table of the shortest-path engine from dest back to src and
//           streams the path forward (src -> dest), then reports path length and done/error.
// Latency : 2 cycles per hop plus 2 (H-hop path accepted at cycle s emits from cycle s+2H+2);
//           one node per cycle after that while out_ready_i is high.
// Backpr. : out_valid_o/out_node_o hold while out_ready_i is low; start_i is ignored while busy.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i, src_i, dest_i        trace request (sampled in IDLE only)
//   par_rd_en_o, par_addr_o       parent table read port (1-cycle read latency)
//   par_rdata_i                   parent[par_addr_o], valid the cycle after par_rd_en_o
//   out_valid_o, out_ready_i      path node stream handshake
//   out_node_o, out_last_o        path node, last-node marker (node == dest)
//   busy_o, done_o, error_o       status: busy span, one-cycle done pulse, sticky error
//   path_len_o                    node count of last successful trace (0 on error)
module dijkstra_path_tracer #(
    parameter int                N_NODES  = 9,
    parameter int                NODE_W   = 4,
    parameter logic [NODE_W-1:0] NONE_IDX = {NODE_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [NODE_W-1:0] src_i,
    input  logic [NODE_W-1:0] dest_i,
    output logic              par_rd_en_o,
    output logic [NODE_W-1:0] par_addr_o,
    input  logic [NODE_W-1:0] par_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [NODE_W-1:0] out_node_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [NODE_W:0]   path_len_o
);

    localparam int                CNT_W     = $clog2(N_NODES + 1);
    localparam int                LEN_W     = NODE_W + 1;
    localparam logic [NODE_W-1:0] N_IDX     = NODE_W'(N_NODES);
    localparam logic [LEN_W-1:0]  MAX_DEPTH = LEN_W'(N_NODES);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [NODE_W-1:0] src_q;
    logic [NODE_W-1:0] cur_q;
    logic [LEN_W-1:0]  depth_q;
    logic [CNT_W-1:0]  sp_q;
    logic              range_err_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [LEN_W-1:0]  path_len_q;
    logic [NODE_W-1:0] stack_q [N_NODES];

    logic              at_src;
    logic              at_max;
    logic              rdata_bad;
    logic              go_err;
    logic              pop;
    logic [CNT_W-1:0]  top_idx;

    // ------------------------------------------------------------------
    // Decisions taken in CHECK / WAIT and the emit handshake
    // ------------------------------------------------------------------
    always_comb begin
        at_src    = (cur_q == src_q);
        at_max    = (depth_q == MAX_DEPTH);
        // NONE_IDX is also >= N_IDX for the default sizing, but a narrower
        // NONE_IDX setting must still be caught explicitly.
        rdata_bad = (par_rdata_i == NONE_IDX) || (par_rdata_i >= N_IDX);
        go_err    = 1'b0;
        if (state_q == S_CHECK) begin
            // Out-of-range endpoints win over everything, so no read is issued.
            go_err = range_err_q || (!at_src && at_max);
        end else if (state_q == S_WAIT) begin
            go_err = rdata_bad;
        end
    end

    // Read is issued in the CHECK cycle itself so the data lands in WAIT.
    always_comb begin
        par_rd_en_o = (state_q == S_CHECK) && !range_err_q && !at_src && !at_max;
        par_addr_o  = par_rd_en_o ? cur_q : '0;
    end

    always_comb begin
        top_idx     = sp_q - CNT_ONE;
        out_valid_o = (state_q == S_EMIT) && (sp_q != '0);
        out_last_o  = out_valid_o && (sp_q == CNT_ONE);
        pop         = out_valid_o && out_ready_i;
        out_node_o  = '0;
        if (out_valid_o) begin
            out_node_o = stack_q[top_idx];
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign path_len_o = path_len_q;

    // ------------------------------------------------------------------
    // Control FSM, stack and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            cur_q       <= '0;
            depth_q     <= '0;
            sp_q        <= '0;
            range_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            path_len_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (go_err) begin
                // Result flags are set on entry so they line up with the
                // ERR cycle, where done is visible.
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                path_len_q <= '0;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                sp_q       <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            src_q       <= src_i;
                            cur_q       <= dest_i;
                            stack_q[0]  <= dest_i;
                            sp_q        <= CNT_ONE;
                            depth_q     <= LEN_ONE;
                            range_err_q <= (src_i >= N_IDX) || (dest_i >= N_IDX);
                            error_q     <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        // Error cases are handled by go_err above.
                        state_q <= at_src ? S_EMIT : S_WAIT;
                    end
                    S_WAIT: begin
                        // depth < N_NODES was checked in CHECK, so this push
                        // always has a free slot.
                        stack_q[sp_q] <= par_rdata_i;
                        sp_q          <= sp_q + CNT_ONE;
                        cur_q         <= par_rdata_i;
                        depth_q       <= depth_q + LEN_ONE;
                        state_q       <= S_CHECK;
                    end
                    S_EMIT: begin
                        if (pop) begin
                            sp_q <= top_idx;
                            if (sp_q == CNT_ONE) begin
                                path_len_q <= depth_q;
                                done_q     <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    S_ERR: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dijkstra_path_tracer.sv
// Directed bench for dijkstra_path_tracer: a registered parent-table model answers
// reads one cycle later; each trace records reads, emitted nodes and final status.
// Stimulus and sampling happen 1 time unit after the rising edge.
module tb_dijkstra_path_tracer;

    localparam int NODE_W  = 4;
    localparam int N_NODES = 9;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [NODE_W-1:0] src_i;
    logic [NODE_W-1:0] dest_i;
    logic              par_rd_en_o;
    logic [NODE_W-1:0] par_addr_o;
    logic [NODE_W-1:0] par_rdata_i = '0;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [NODE_W-1:0] out_node_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [NODE_W:0]   path_len_o;

    dijkstra_path_tracer #(.N_NODES(N_NODES), .NODE_W(NODE_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .src_i       (src_i),
        .dest_i      (dest_i),
        .par_rd_en_o (par_rd_en_o),
        .par_addr_o  (par_addr_o),
        .par_rdata_i (par_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_node_o  (out_node_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .path_len_o  (path_len_o)
    );

    always #5 clk_i = ~clk_i;

    // Parent table model with one-cycle read latency.
    logic [NODE_W-1:0] ptab [16];
    always @(posedge clk_i) begin
        if (par_rd_en_o) par_rdata_i <= ptab[par_addr_o];
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-trace observations.
    int nodes_q[$];
    int rd_q[$];
    int n_last, last_pos, first_valid, valid_cnt, stall_err;
    int got_err, got_len, got_busy, s_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_std_table();
        for (int i = 0; i < 16; i++) ptab[i] = 4'hF;
        ptab[0] = 4'd15; ptab[1] = 4'd0; ptab[2] = 4'd1;
        ptab[3] = 4'd0;  ptab[4] = 4'd1; ptab[5] = 4'd2;
        ptab[6] = 4'd3;  ptab[7] = 4'd4; ptab[8] = 4'd7;
    endtask

    task automatic do_start(input int s, input int d);
        src_i   = NODE_W'(s);
        dest_i  = NODE_W'(d);
        start_i = 1'b1;
        s_cyc   = cyc;
        tick();
        start_i = 1'b0;
    endtask

    // Observes one trace until done (bounded); toggle = out_ready alternates,
    // mid_start = pulse a competing start while the trace is in progress.
    task automatic run_trace(input bit toggle, input bit mid_start);
        bit pv, pr, done_seen;
        int pn, m;
        nodes_q.delete();
        rd_q.delete();
        n_last = 0; last_pos = -1; first_valid = -1; valid_cnt = 0; stall_err = 0;
        got_err = -1; got_len = -1; got_busy = -1;
        pv = 1'b0; pr = 1'b0; pn = 0; done_seen = 1'b0;
        for (int k = 0; k < 300 && !done_seen; k++) begin
            m = cyc - s_cyc;
            out_ready_i = toggle ? (m % 2 == 0) : 1'b1;
            start_i = mid_start && (m == 4);
            if (start_i) begin
                src_i  = 4'd3;
                dest_i = 4'd5;
            end
            if (par_rd_en_o) rd_q.push_back(int'(par_addr_o));
            if (pv && !pr && (!out_valid_o || int'(out_node_o) != pn)) stall_err++;
            if (out_valid_o) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = m;
                if (out_ready_i) begin
                    nodes_q.push_back(int'(out_node_o));
                    if (out_last_o) begin
                        n_last++;
                        last_pos = nodes_q.size() - 1;
                    end
                end
            end
            pv = out_valid_o;
            pr = out_ready_i;
            pn = int'(out_node_o);
            if (done_o) begin
                done_seen = 1'b1;
                got_err   = int'(error_o);
                got_len   = int'(path_len_o);
                got_busy  = int'(busy_o);
            end else begin
                tick();
            end
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        chk("done_seen", done_seen, 1);
    endtask

    task automatic chk_seq(input string tag, input int q[$], input int exp[$]);
        chk({tag, "_len"}, q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : 99, exp[i]);
    endtask

    // After done: the pulse is single-cycle and busy stays low.
    task automatic chk_after_done(input string tag);
        tick();
        chk({tag, "_done_pulse"}, done_o, 0);
        chk({tag, "_busy_after"}, busy_o, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},      busy_o, 0);
        chk({tag, "_done"},      done_o, 0);
        chk({tag, "_error"},     error_o, 0);
        chk({tag, "_out_valid"}, out_valid_o, 0);
        chk({tag, "_out_last"},  out_last_o, 0);
        chk({tag, "_rd_en"},     par_rd_en_o, 0);
        chk({tag, "_par_addr"},  par_addr_o, 0);
        chk({tag, "_out_node"},  out_node_o, 0);
        chk({tag, "_path_len"},  path_len_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        load_std_table();
        rst_ni = 1'b0; start_i = 1'b0; src_i = '0; dest_i = '0; out_ready_i = 1'b0;
        tick(); tick(); tick();
        chk_idle_outputs("reset");
        rst_ni = 1'b1;
        tick();

        // 1: 0 -> 8 over the standard table.
        do_start(0, 8);
        run_trace(1'b0, 1'b0);
        chk_seq("t1_reads", rd_q, '{8, 7, 4, 1});
        chk("t1_first_valid", first_valid, 10);
        chk_seq("t1_nodes", nodes_q, '{0, 1, 4, 7, 8});
        chk("t1_last_cnt", n_last, 1);
        chk("t1_last_pos", last_pos, 4);
        chk("t1_path_len", got_len, 5);
        chk("t1_error", got_err, 0);
        chk("t1_busy_at_done", got_busy, 0);
        chk_after_done("t1");

        // 2: src == dest, no reads.
        do_start(0, 0);
        run_trace(1'b0, 1'b0);
        chk("t2_reads", rd_q.size(), 0);
        chk("t2_first_valid", first_valid, 2);
        chk_seq("t2_nodes", nodes_q, '{0});
        chk("t2_last_cnt", n_last, 1);
        chk("t2_path_len", got_len, 1);
        chk("t2_error", got_err, 0);
        chk_after_done("t2");

        // 3: unreachable (chain ends at NONE before reaching src 3).
        do_start(3, 5);
        run_trace(1'b0, 1'b0);
        chk_seq("t3_reads", rd_q, '{5, 2, 1, 0});
        chk("t3_error", got_err, 1);
        chk("t3_path_len", got_len, 0);
        chk("t3_valid_cnt", valid_cnt, 0);
        chk_after_done("t3");
        chk("t3_error_sticky", error_o, 1);

        // 4: cyclic table, ERR once depth hits N_NODES.
        ptab[1] = 4'd2;
        ptab[2] = 4'd1;
        do_start(0, 1);
        run_trace(1'b0, 1'b0);
        chk("t4_reads", rd_q.size(), 8);
        chk("t4_error", got_err, 1);
        chk("t4_path_len", got_len, 0);
        chk("t4_busy_at_done", got_busy, 0);
        chk("t4_valid_cnt", valid_cnt, 0);
        chk_after_done("t4");
        load_std_table();

        // 7: out-of-range destination, no reads.
        do_start(0, 9);
        run_trace(1'b0, 1'b0);
        chk("t7_reads", rd_q.size(), 0);
        chk("t7_error", got_err, 1);
        chk("t7_valid_cnt", valid_cnt, 0);
        chk_after_done("t7");

        // 5: stalling sink plus an ignored mid-trace start.
        do_start(0, 8);
        run_trace(1'b1, 1'b1);
        chk_seq("t5_nodes", nodes_q, '{0, 1, 4, 7, 8});
        chk("t5_stall_err", stall_err, 0);
        chk("t5_last_pos", last_pos, 4);
        chk("t5_path_len", got_len, 5);
        chk("t5_error", got_err, 0);
        chk_after_done("t5");

        // 6: reset during EMIT after node 1 has been popped.
        out_ready_i = 1'b0;
        do_start(0, 8);
        for (int k = 0; k < 50 && !out_valid_o; k++) tick();
        chk("t6_valid", out_valid_o, 1);
        chk("t6_node0", out_node_o, 0);
        out_ready_i = 1'b1;
        tick();
        chk("t6_node1", out_node_o, 1);
        tick();
        chk("t6_node4", out_node_o, 4);
        rst_ni = 1'b0;
        out_ready_i = 1'b0;
        tick();
        chk_idle_outputs("t6_rst");
        rst_ni = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_o || busy_o || out_valid_o) saw_done = 1'b1;
        end
        chk("t6_quiet_after_rst", saw_done, 0);
        do_start(0, 8);
        run_trace(1'b0, 1'b0);
        chk_seq("t6_nodes", nodes_q, '{0, 1, 4, 7, 8});
        chk("t6_path_len", got_len, 5);
        chk("t6_error", got_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dijkstra_path_tracer.md
Name: dijkstra_path_tracer

Overview:
- Consumer of the parent[] table produced by the dijkstra block; the reader end of that table.
- Walks parent pointers from dest back to src, holding them on an internal LIFO stack.
- Streams the node sequence src -> dest in forward order over a valid/ready interface, followed by a path length and done/error status.
- Sits between the shortest-path engine and the result/print logic.

Parameters:
N_NODES, 9, number of graph nodes (max path length, stack depth).
NODE_W, 4, node index width; needs 2^NODE_W > N_NODES.
NONE_IDX, 2^NODE_W-1, parent value meaning "no parent" (the -1 of the parent table).

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  single-cycle request; sampled only in IDLE.
src  in  NODE_W  source node, latched on accepted start.
dest  in  NODE_W  destination node, latched on accepted start.
par_rd_en  out  1  parent table read strobe.
par_addr  out  NODE_W  parent table read address.
par_rdata  in  NODE_W  parent[par_addr], valid exactly 1 cycle after par_rd_en.
out_valid  out  1  path node available.
out_ready  in  1  downstream accepts node.
out_node  out  NODE_W  path node index.
out_last  out  1  marks the final node (== dest).
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse at end of trace (success or error).
error  out  1  sticky result flag, valid with done; cleared on next accepted start.
path_len  out  NODE_W+1  number of nodes in the path; held until next start; 0 on error.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. busy, done, error, out_valid, out_last, par_rd_en = 0. path_len = 0. Stack pointer = 0. par_addr and out_node = 0.
- Reset mid-operation aborts immediately: the stack is discarded, no done pulse is produced, and the block returns to IDLE.
- IDLE:
  - On start: latch src/dest, push dest, cur = dest, depth = 1, clear error, busy = 1, go to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle):
  - If cur == src: go to EMIT.
  - Else if depth == N_NODES: go to ERR (loop or overlong chain).
  - Else: assert par_rd_en, par_addr = cur, go to WAIT.
- WAIT (1 cycle):
  - Sample par_rdata.
  - If par_rdata == NONE_IDX or par_rdata >= N_NODES: go to ERR (unreachable or corrupt table).
  - Else: push par_rdata, cur = par_rdata, depth += 1, go to CHECK.
- Timing: each hop costs 2 cycles. For a path of H hops accepted at cycle s, EMIT is entered at s+2H+2 and out_valid first rises in that cycle.
- EMIT:
  - out_valid = (stack not empty).
  - out_node = top of stack (combinational from stack registers).
  - out_last = (stack count == 1).
  - Pop on out_valid && out_ready.
  - out_node/out_valid hold stable while out_ready = 0.
  - On the pop of the last node: path_len = depth, go to DONE.
- DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- ERR: error = 1, path_len = 0, done = 1 for one cycle, busy = 0, stack cleared, go to IDLE. No out_valid is ever raised for an errored trace.
- src == dest: no table reads; a single node is emitted with out_last = 1; path_len = 1.
- Out-of-range inputs: src or dest >= N_NODES at start goes to ERR on the next cycle without any reads.
- Stack: N_NODES entries x NODE_W.
  - Overflow is impossible: the depth check precedes every push.
  - Underflow is impossible: pop is gated by not-empty.
- path_len arithmetic is unsigned and saturates by construction at N_NODES.

Test Plan:
1. Parent table from the standard 9-node graph, src 0 (parent = 15,0,1,0,1,2,3,4,7). src=0, dest=8, out_ready=1:
   - reads at addr 8,7,4,1;
   - out_valid rises at s+10;
   - emits 0,1,4,7,8 with out_last on 8;
   - done pulses with path_len = 5, error = 0.
2. Same table, src=0, dest=0 -> no par_rd_en; single node 0 with out_last; path_len = 1.
3. Same table, src=3, dest=5 (chain 5,2,1,0 then parent[0] = 15) -> error = 1, path_len = 0, done pulse, out_valid never high.
4. Cyclic table parent[1]=2, parent[2]=1, src=0, dest=1 -> ERR after depth reaches 9; done + error; busy low.
5. Scenario 1 with out_ready toggling 1/0 each cycle -> same 0,1,4,7,8 sequence, no drops or duplicates, out_node stable while stalled; start pulsed mid-trace is ignored.
6. rst_n=0 during EMIT after node 1 is popped -> next cycle all outputs 0, state IDLE; a fresh start for 0->8 yields the full 5-node path.
